// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared AXI4-Lite constants: response codes and the state
//                encodings of the AXI-Lite register master.
//  Contents    : RESP_* response codes, state_t type, c_st_* state encodings
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    // Code reported to the command source when the master aborts on timeout
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    // Register-master state encoding
    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_wr_req  = 3'd1;
    localparam state_t c_st_wr_resp = 3'd2;
    localparam state_t c_st_rd_req  = 3'd3;
    localparam state_t c_st_rd_resp = 3'd4;
    localparam state_t c_st_resp    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/axi_lite_reg_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_reg_master
//  Description : Converts a single-beat command/response interface into
//                AXI4-Lite read/write transactions, one outstanding at a
//                time, with a per-transaction abort timeout.
//  Ports       : i_axi_clk / i_axi_rst (sync, active-low)
//                cmd  : i_cmd_valid/o_cmd_ready, i_cmd_write, i_cmd_addr,
//                       i_cmd_data, i_cmd_strb
//                rsp  : o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_resp,
//                       o_rsp_timeout
//                AXI  : AW, W, B, AR, R channels (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    i_axi_clk,
    input  logic                    i_axi_rst,
    // command interface
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
    // response interface
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,
    // AXI write address
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    // AXI write data
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    // AXI write response
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,
    // AXI read address
    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    // AXI read data
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter then.
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The abort is taken on the edge where the counter would step onto
    // TIMEOUT_CYCLES, so the pre-edge value compared is one less.
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

    // registered state and outputs
    state_t                  r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_cmd_ready;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STROBE_WIDTH-1:0] r_wstrb;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [1:0]              r_rsp_resp;
    logic                    r_rsp_timeout;

    // next-state values
    state_t                  w_state_nxt;
    logic [c_cnt_w-1:0]      w_cnt_nxt;
    logic                    w_cmd_ready_nxt;
    logic                    w_awvalid_nxt;
    logic                    w_wvalid_nxt;
    logic                    w_bready_nxt;
    logic                    w_arvalid_nxt;
    logic                    w_rready_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_wdata_nxt;
    logic [STROBE_WIDTH-1:0] w_wstrb_nxt;
    logic                    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_data_nxt;
    logic [1:0]              w_rsp_resp_nxt;
    logic                    w_rsp_timeout_nxt;

    logic                    w_active;
    logic                    w_timeout_hit;
    logic                    w_completion;

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_awvalid_nxt     = r_awvalid;
        w_wvalid_nxt      = r_wvalid;
        w_bready_nxt      = r_bready;
        w_arvalid_nxt     = r_arvalid;
        w_rready_nxt      = r_rready;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_wstrb_nxt       = r_wstrb;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;

        w_active      = (r_state == c_st_wr_req) || (r_state == c_st_wr_resp) ||
                        (r_state == c_st_rd_req) || (r_state == c_st_rd_resp);
        w_timeout_hit = (TIMEOUT_CYCLES > 0) && w_active && (r_cnt == c_cnt_last);
        // Only the final B/R handshake counts as completion; it beats a
        // timeout landing on the same edge.
        w_completion  = ((r_state == c_st_wr_resp) && r_bready && i_bvalid) ||
                        ((r_state == c_st_rd_resp) && r_rready && i_rvalid);

        if (w_active) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        case (r_state)
            c_st_idle: begin
                if (r_cmd_ready && i_cmd_valid) begin
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = i_cmd_addr;
                    w_wdata_nxt = i_cmd_data;
                    w_wstrb_nxt = i_cmd_strb;
                    if (i_cmd_write) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = c_st_wr_req;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = c_st_rd_req;
                    end
                end
            end
            c_st_wr_req: begin
                // AW and W retire independently; move on once both are gone.
                w_awvalid_nxt = r_awvalid && !i_awready;
                w_wvalid_nxt  = r_wvalid && !i_wready;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = c_st_wr_resp;
                end
            end
            c_st_wr_resp: begin
                if (r_bready && i_bvalid) begin
                    w_bready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_data_nxt    = '0;
                    w_rsp_resp_nxt    = i_bresp;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = c_st_resp;
                end
            end
            c_st_rd_req: begin
                if (r_arvalid && i_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = c_st_rd_resp;
                end
            end
            c_st_rd_resp: begin
                if (r_rready && i_rvalid) begin
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_data_nxt    = i_rdata;
                    w_rsp_resp_nxt    = i_rresp;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = c_st_resp;
                end
            end
            c_st_resp: begin
                if (r_rsp_valid && i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        // Abort: withdraw every AXI request and report a synthetic response.
        if (w_timeout_hit && !w_completion) begin
            w_awvalid_nxt     = 1'b0;
            w_wvalid_nxt      = 1'b0;
            w_bready_nxt      = 1'b0;
            w_arvalid_nxt     = 1'b0;
            w_rready_nxt      = 1'b0;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_data_nxt    = '0;
            w_rsp_resp_nxt    = RESP_TIMEOUT;
            w_rsp_timeout_nxt = 1'b1;
            w_state_nxt       = c_st_resp;
        end

        // Registered ready: high exactly while the FSM sits in IDLE.
        w_cmd_ready_nxt = (w_state_nxt == c_st_idle);
    end

    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_bready      <= w_bready_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_rready      <= w_rready_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= w_wstrb_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_awvalid     = r_awvalid;
    assign o_awaddr      = r_addr;
    assign o_wvalid      = r_wvalid;
    assign o_wdata       = r_wdata;
    assign o_wstrb       = r_wstrb;
    assign o_bready      = r_bready;
    assign o_arvalid     = r_arvalid;
    assign o_araddr      = r_addr;
    assign o_rready      = r_rready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_resp    = r_rsp_resp;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_reg_master
//  Description : Directed self-checking bench for axi_lite_reg_master with
//                TIMEOUT_CYCLES=16. Cycle n is the clock period following
//                accept edge n-1; checks sample 1ns after the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_master;

    localparam int ADDR_WIDTH     = 16;
    localparam int DATA_WIDTH     = 32;
    localparam int STROBE_WIDTH   = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_data;
    logic [STROBE_WIDTH-1:0] cmd_strb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [1:0]              rsp_resp;
    logic                    rsp_timeout;
    logic                    awvalid, awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid, wready;
    logic [STROBE_WIDTH-1:0] wstrb;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    bvalid, bready;
    logic [1:0]              bresp;
    logic                    arvalid, arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid, rready;
    logic [1:0]              rresp;
    logic [DATA_WIDTH-1:0]   rdata;

    int n_tests = 0;
    int n_fail  = 0;

    axi_lite_reg_master #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .STROBE_WIDTH  (STROBE_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dut (
        .i_axi_clk    (clk),
        .i_axi_rst    (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_write  (cmd_write),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_data   (cmd_data),
        .i_cmd_strb   (cmd_strb),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_resp   (rsp_resp),
        .o_rsp_timeout(rsp_timeout),
        .o_awvalid    (awvalid),
        .i_awready    (awready),
        .o_awaddr     (awaddr),
        .o_wvalid     (wvalid),
        .i_wready     (wready),
        .o_wstrb      (wstrb),
        .o_wdata      (wdata),
        .i_bvalid     (bvalid),
        .o_bready     (bready),
        .i_bresp      (bresp),
        .o_arvalid    (arvalid),
        .i_arready    (arready),
        .o_araddr     (araddr),
        .i_rvalid     (rvalid),
        .o_rready     (rready),
        .i_rresp      (rresp),
        .i_rdata      (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [ADDR_WIDTH-1:0] a,
                         input logic [DATA_WIDTH-1:0] d, input logic [STROBE_WIDTH-1:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_strb  = s;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_data = '0; cmd_strb = '0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("rst_rsp", {rsp_data, rsp_resp, rsp_timeout}, 0);
        chk("rst_addr", {awaddr, araddr}, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // ---------------- 1: zero-wait write ----------------
        issue(1'b1, 16'h0000, 32'hDEADBEEF, 4'hF);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b1;
        tick();                                   // cycle 1
        cmd_valid = 1'b0;
        chk("w1_c1_awvalid", awvalid, 1);
        chk("w1_c1_wvalid", wvalid, 1);
        chk("w1_c1_wdata", wdata, 32'hDEADBEEF);
        chk("w1_c1_wstrb", wstrb, 4'hF);
        chk("w1_c1_cmd_ready", cmd_ready, 0);
        tick();                                   // cycle 2
        chk("w1_c2_aw_w", {awvalid, wvalid}, 2'b00);
        chk("w1_c2_bready", bready, 1);
        tick();                                   // cycle 3
        chk("w1_c3_rsp_valid", rsp_valid, 1);
        chk("w1_c3_rsp", {rsp_data, rsp_resp, rsp_timeout}, 0);
        chk("w1_c3_bready", bready, 0);
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        tick();                                   // cycle 4
        chk("w1_c4_rsp_valid", rsp_valid, 0);
        chk("w1_c4_cmd_ready", cmd_ready, 1);

        // ---------------- 2: read with 2-cycle arready delay ----------------
        issue(1'b0, 16'h0004, 32'h0, 4'h0);
        tick();                                   // cycle 1
        cmd_valid = 1'b0;
        chk("r2_c1_arvalid", arvalid, 1);
        chk("r2_c1_araddr", araddr, 16'h0004);
        tick(); tick();                           // cycle 3
        chk("r2_c3_arvalid", arvalid, 1);
        chk("r2_c3_rready", rready, 0);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h10000000; rresp = 2'b00;
        tick();                                   // cycle 4
        arready = 1'b0;
        chk("r2_c4_arvalid", arvalid, 0);
        chk("r2_c4_rready", rready, 1);
        tick();                                   // cycle 5
        rvalid = 1'b0;
        chk("r2_c5_rsp_valid", rsp_valid, 1);
        chk("r2_c5_rsp_data", rsp_data, 32'h10000000);
        chk("r2_c5_rsp_resp", {rsp_resp, rsp_timeout}, 3'b000);
        tick();                                   // cycle 6
        chk("r2_c6_cmd_ready", cmd_ready, 1);

        // ---------------- 3: write, awready late, SLVERR, stalled response ----
        rsp_ready = 1'b0;
        issue(1'b1, 16'h0100, 32'h0000ABCD, 4'h3);
        wready = 1'b1;
        tick();                                   // cycle 1
        cmd_valid = 1'b0;
        chk("w3_c1_aw_w", {awvalid, wvalid}, 2'b11);
        chk("w3_c1_awaddr", awaddr, 16'h0100);
        chk("w3_c1_wstrb", wstrb, 4'h3);
        tick();                                   // cycle 2
        wready = 1'b0;
        chk("w3_c2_wvalid", wvalid, 0);
        chk("w3_c2_awvalid", awvalid, 1);
        chk("w3_c2_bready", bready, 0);
        repeat (4) tick();                        // cycle 6
        chk("w3_c6_awvalid", awvalid, 1);
        chk("w3_c6_bready", bready, 0);
        awready = 1'b1;
        tick();                                   // cycle 7
        awready = 1'b0;
        chk("w3_c7_awvalid", awvalid, 0);
        chk("w3_c7_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b10;
        tick();                                   // cycle 8
        bvalid = 1'b0; bresp = 2'b00;
        issue(1'b0, 16'h0055, 32'h0, 4'h0);       // must be ignored while in RESP
        for (int i = 0; i < 5; i++) begin
            chk("w3_stall_rsp_valid", rsp_valid, 1);
            chk("w3_stall_rsp", {rsp_data, rsp_resp, rsp_timeout}, {32'h0, 2'b10, 1'b0});
            chk("w3_stall_cmd_ready", cmd_ready, 0);
            chk("w3_stall_arvalid", arvalid, 0);
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        tick();
        chk("w3_done_rsp_valid", rsp_valid, 0);
        chk("w3_done_cmd_ready", cmd_ready, 1);
        chk("w3_done_no_rd", arvalid, 0);

        // ---------------- 4: timeout, slave never raises arready -------------
        issue(1'b0, 16'h0008, 32'h0, 4'h0);
        tick();                                   // cycle 1
        cmd_valid = 1'b0;
        chk("t4_c1_arvalid", arvalid, 1);
        repeat (15) tick();                       // cycle 16
        chk("t4_c16_arvalid", arvalid, 1);
        chk("t4_c16_rsp_valid", rsp_valid, 0);
        tick();                                   // cycle 17
        chk("t4_c17_arvalid", arvalid, 0);
        chk("t4_c17_rsp_valid", rsp_valid, 1);
        chk("t4_c17_rsp", {rsp_data, rsp_resp, rsp_timeout}, {32'h0, 2'b11, 1'b1});
        tick();                                   // cycle 18
        chk("t4_c18_cmd_ready", cmd_ready, 1);
        // follow-up read with slave error passthrough
        issue(1'b0, 16'h000C, 32'h0, 4'h0);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b10;
        tick();
        cmd_valid = 1'b0;
        chk("t4_next_araddr", araddr, 16'h000C);
        tick();
        chk("t4_next_rready", rready, 1);
        tick();
        arready = 1'b0; rvalid = 1'b0;
        chk("t4_next_rsp_valid", rsp_valid, 1);
        chk("t4_next_rsp", {rsp_data, rsp_resp, rsp_timeout}, {32'hCAFEF00D, 2'b10, 1'b0});
        tick();

        // ---------------- 6: reset while in WR_RESP --------------------------
        issue(1'b1, 16'h0010, 32'h00000001, 4'hF);
        awready = 1'b1; wready = 1'b1;
        tick();                                   // cycle 1
        cmd_valid = 1'b0;
        tick();                                   // cycle 2
        chk("r6_c2_bready", bready, 1);
        rst_n = 1'b0; bvalid = 1'b1;
        tick();
        chk("r6_rst_valids", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("r6_rst_rsp", {rsp_data, rsp_resp, rsp_timeout}, 0);
        chk("r6_rst_awaddr", awaddr, 0);
        rst_n = 1'b1; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        tick();
        chk("r6_cmd_ready", cmd_ready, 1);
        issue(1'b0, 16'h0020, 32'h0, 4'h0);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
        tick();
        cmd_valid = 1'b0;
        chk("r6_rd_arvalid", arvalid, 1);
        tick();
        tick();
        arready = 1'b0; rvalid = 1'b0;
        chk("r6_rd_rsp_valid", rsp_valid, 1);
        chk("r6_rd_rsp", {rsp_data, rsp_resp, rsp_timeout}, {32'h12345678, 2'b00, 1'b0});
        tick();
        chk("r6_rd_idle", {rsp_valid, cmd_ready}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
